// File: rtl/ecb_d_iter_if.sv
// Handshake bundle for the iterative AES-128 ECB decryptor: an input channel
// carrying ciphertext and key, and an output channel carrying plaintext.
interface ecb_d_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plaintext;

   modport master (
      output in_valid, ciphertext, key, out_ready,
      input  in_ready, out_valid, plaintext
   );

   modport slave (
      input  in_valid, ciphertext, key, out_ready,
      output in_ready, out_valid, plaintext
   );
endinterface

// File: rtl/ecb_d_iter.sv
// Iterative AES-128 ECB decryptor (FIPS-197 inverse cipher), one round per
// clock. The forward key schedule is expanded once per key and kept in a small
// round-key store, so blocks that reuse the previous key skip the expansion.
module ecb_d_iter (
   input  logic        clk_i,
   input  logic        rst_n_i,
   ecb_d_iter_if.slave bus
);

   typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, LOAD, DONE} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // GF(2^8) helpers: multiply by x, then the InvMixColumns constants as xtime chains
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ a;
   endfunction

   function automatic logic [7:0] mulB(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
   endfunction

   function automatic logic [7:0] mulD(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
   endfunction

   function automatic logic [7:0] mulE(input logic [7:0] a);
      return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
   endfunction

   function automatic logic [31:0] invMixColumn(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {mulE(a0) ^ mulB(a1) ^ mulD(a2) ^ mul9(a3),
              mul9(a0) ^ mulE(a1) ^ mulB(a2) ^ mulD(a3),
              mulD(a0) ^ mul9(a1) ^ mulE(a2) ^ mulB(a3),
              mulB(a0) ^ mulD(a1) ^ mul9(a2) ^ mulE(a3)};
   endfunction

   function automatic logic [127:0] invMixColumns(input logic [127:0] s);
      return {invMixColumn(s[127:96]), invMixColumn(s[95:64]),
              invMixColumn(s[63:32]),  invMixColumn(s[31:0])};
   endfunction

   // Row k is rotated right by k columns: out[row][c] = in[row][c-row]
   function automatic logic [127:0] invShiftRows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] invSubBytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         r[127 - 8*i -: 8] = INV_SBOX[s[127 - 8*i -: 8]];
      end
      return r;
   endfunction

   function automatic logic [7:0] rconOf(input logic [3:0] idx);
      logic [7:0] rc;
      case (idx)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // One step of the forward schedule: four words of rk[i] from rk[i-1]
   function automatic logic [127:0] expandKey(input logic [127:0] prev, input logic [7:0] rc);
      logic [31:0] t, w0, w1, w2, w3;
      t = {SBOX[prev[23:16]], SBOX[prev[15:8]], SBOX[prev[7:0]], SBOX[prev[31:24]]}
          ^ {rc, 24'h000000};
      w0 = prev[127:96] ^ t;
      w1 = prev[95:64]  ^ w0;
      w2 = prev[63:32]  ^ w1;
      w3 = prev[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   state_t       state_q, state_d;
   logic [3:0]   count_q, count_d;
   logic [127:0] block_q, block_d;
   logic [127:0] work_q, work_d;
   logic         cacheValid_q, cacheValid_d;
   logic [127:0] plaintext_q, plaintext_d;
   logic         outValid_q, outValid_d;
   logic [127:0] roundKey_q [11];

   logic         rkWe;
   logic [3:0]   rkIdx;
   logic [127:0] rkData;
   logic [127:0] roundKey;
   logic [127:0] nextKey;
   logic [127:0] afterAdd;
   logic         cacheHit;

   assign roundKey = roundKey_q[count_q];
   assign nextKey  = expandKey(work_q, rconOf(count_q));
   assign afterAdd = invSubBytes(invShiftRows(block_q)) ^ roundKey;
   assign cacheHit = cacheValid_q && (bus.key == roundKey_q[0]);

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = outValid_q;
   assign bus.plaintext = plaintext_q;

   // Control and datapath registers; reset wins over anything in flight and drops the cache
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         count_q      <= '0;
         block_q      <= '0;
         work_q       <= '0;
         cacheValid_q <= 1'b0;
         plaintext_q  <= '0;
         outValid_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         block_q      <= block_d;
         work_q       <= work_d;
         cacheValid_q <= cacheValid_d;
         plaintext_q  <= plaintext_d;
         outValid_q   <= outValid_d;
      end
   end

   // Round-key store; rk0 doubles as the cached key and is only trusted while cacheValid_q is set
   always_ff @(posedge clk_i) begin
      if (rkWe) begin
         roundKey_q[rkIdx] <= rkData;
      end
   end

   // Next-state logic: count_q is the rcon index during KEXP and the round number afterwards
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      block_d      = block_q;
      work_d       = work_q;
      cacheValid_d = cacheValid_q;
      plaintext_d  = plaintext_q;
      outValid_d   = outValid_q;
      rkWe         = 1'b0;
      rkIdx        = count_q;
      rkData       = nextKey;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               block_d = bus.ciphertext;
               if (cacheHit) begin
                  count_d = 4'd10;
                  state_d = INIT;
               end else begin
                  rkWe         = 1'b1;
                  rkIdx        = 4'd0;
                  rkData       = bus.key;
                  work_d       = bus.key;
                  cacheValid_d = 1'b0;
                  count_d      = 4'd1;
                  state_d      = KEXP;
               end
            end
         end
         KEXP: begin
            rkWe   = 1'b1;
            work_d = nextKey;
            if (count_q == 4'd10) begin
               cacheValid_d = 1'b1;
               state_d      = INIT;
            end else begin
               count_d = count_q + 4'd1;
            end
         end
         INIT: begin
            block_d = block_q ^ roundKey;
            count_d = 4'd9;
            state_d = ROUND;
         end
         ROUND: begin
            if (count_q == 4'd0) begin
               block_d = afterAdd;
               state_d = LOAD;
            end else begin
               block_d = invMixColumns(afterAdd);
               count_d = count_q - 4'd1;
            end
         end
         LOAD: begin
            plaintext_d = block_q;
            outValid_d  = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               outValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ecb_d_iter.sv
// Directed and round-trip bench for the iterative AES-128 ECB decryptor.
module tb_ecb_d_iter;

   logic clk;
   logic rstN;
   int   checkCount;
   int   passCount;

   logic [7:0] sboxModel [256];

   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

   ecb_d_iter_if bus ();

   ecb_d_iter dut (
      .clk_i   (clk),
      .rst_n_i (rstN),
      .bus     (bus)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] a);
      return {a[6:0], a[7]};
   endfunction

   // Forward S-box derived from the field inverse and the affine map
   task automatic buildSbox();
      logic [7:0] inv, b, x8, y8;
      for (int x = 0; x < 256; x++) begin
         x8  = x[7:0];
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            y8 = y[7:0];
            if (gmul(x8, y8) == 8'h01) inv = y8;
         end
         b = inv;
         sboxModel[x] = b ^ rotl1(b) ^ rotl1(rotl1(b)) ^ rotl1(rotl1(rotl1(b)))
                        ^ rotl1(rotl1(rotl1(rotl1(b)))) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] encryptModel(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] rk [11];
      logic [127:0] s, t128;
      logic [31:0]  t, w0, w1, w2, w3;
      logic [7:0]   rc, a0, a1, a2, a3;
      rk[0] = key;
      rc    = 8'h01;
      for (int i = 1; i < 11; i++) begin
         t  = {sboxModel[rk[i-1][23:16]], sboxModel[rk[i-1][15:8]],
               sboxModel[rk[i-1][7:0]],   sboxModel[rk[i-1][31:24]]} ^ {rc, 24'h000000};
         w0 = rk[i-1][127:96] ^ t;
         w1 = rk[i-1][95:64]  ^ w0;
         w2 = rk[i-1][63:32]  ^ w1;
         w3 = rk[i-1][31:0]   ^ w2;
         rk[i] = {w0, w1, w2, w3};
         rc = xt(rc);
      end
      s = pt ^ rk[0];
      for (int r = 1; r < 11; r++) begin
         for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = sboxModel[s[127 - 8*i -: 8]];
         t128 = s;
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[127 - 8*(4*c + row) -: 8] = t128[127 - 8*(4*((c + row) % 4) + row) -: 8];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[127 - 32*c -: 8];
               a1 = s[119 - 32*c -: 8];
               a2 = s[111 - 32*c -: 8];
               a3 = s[103 - 32*c -: 8];
               s[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
         end
         s = s ^ rk[r];
      end
      return s;
   endfunction

   // Waits (bounded) for in_ready, then presents one block for exactly one edge
   task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] key);
      int n;
      n = 0;
      while (!bus.in_ready && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) checkOutput("inReadyTimeout", 128'(bus.in_ready), 128'd1);
      bus.ciphertext = ct;
      bus.key        = key;
      bus.in_valid   = 1'b1;
      @(posedge clk); #1;
      bus.in_valid   = 1'b0;
      bus.ciphertext = ~ct;
      bus.key        = ~key;
   endtask

   task automatic waitForOutput(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic runBlock(input string tag, input logic [127:0] ct, input logic [127:0] key,
                           input logic [127:0] expPt, input int expLat);
      int lat;
      applyStimulus(ct, key);
      waitForOutput(lat);
      checkOutput({tag, "-lat"}, 128'(lat), 128'(expLat));
      checkOutput({tag, "-pt"}, bus.plaintext, expPt);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic drainRandom(output logic [127:0] pt);
      bit done;
      done = 1'b0;
      pt   = '0;
      for (int n = 0; n < 64 && !done; n++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (bus.out_valid && bus.out_ready) begin
            pt   = bus.plaintext;
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      if (!done) checkOutput("drainTimeout", 128'd0, 128'd1);
   endtask

   // Main directed sequence followed by the randomised round trip
   initial begin
      int           lat;
      logic [127:0] curKey, image, ct, got;
      checkCount     = 0;
      passCount      = 0;
      rstN           = 1'b0;
      bus.in_valid   = 1'b0;
      bus.ciphertext = '0;
      bus.key        = '0;
      bus.out_ready  = 1'b0;
      buildSbox();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst-inReady", 128'(bus.in_ready), 128'd1);
      checkOutput("rst-outValid", 128'(bus.out_valid), 128'd0);
      checkOutput("rst-pt", bus.plaintext, 128'd0);
      rstN = 1'b1;
      @(posedge clk); #1;

      runBlock("appB", CT_B, KEY_B, PT_B, 22);
      runBlock("c1-miss", CT_C, KEY_C, PT_C, 22);
      runBlock("c1-hit", CT_C, KEY_C, PT_C, 12);

      applyStimulus(CT_C, KEY_C);
      waitForOutput(lat);
      checkOutput("bp-lat", 128'(lat), 128'd12);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            bus.ciphertext = CT_B;
            bus.key        = KEY_B;
            bus.in_valid   = 1'b1;
         end else begin
            bus.in_valid   = 1'b0;
         end
         @(posedge clk); #1;
         checkOutput("bp-pt", bus.plaintext, PT_C);
         checkOutput("bp-outValid", 128'(bus.out_valid), 128'd1);
         checkOutput("bp-inReady", 128'(bus.in_ready), 128'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("bp-release-outValid", 128'(bus.out_valid), 128'd0);
      checkOutput("bp-release-inReady", 128'(bus.in_ready), 128'd1);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("bp-ignored-outValid", 128'(bus.out_valid), 128'd0);
      checkOutput("bp-ignored-inReady", 128'(bus.in_ready), 128'd1);

      applyStimulus(CT_C, KEY_C);
      repeat (5) @(posedge clk);
      #1;
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
      checkOutput("rstRound-outValid", 128'(bus.out_valid), 128'd0);
      checkOutput("rstRound-pt", bus.plaintext, 128'd0);
      checkOutput("rstRound-inReady", 128'(bus.in_ready), 128'd1);
      runBlock("rstRound-rekey", CT_C, KEY_C, PT_C, 22);

      applyStimulus(CT_B, KEY_B);
      repeat (4) @(posedge clk);
      #1;
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
      checkOutput("rstKexp-inReady", 128'(bus.in_ready), 128'd1);
      runBlock("rstKexp-rekey", CT_B, KEY_B, PT_B, 22);
      runBlock("rstKexp-hit", CT_B, KEY_B, PT_B, 12);

      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) runBlock("alt-c1", CT_C, KEY_C, PT_C, 22);
         else            runBlock("alt-b", CT_B, KEY_B, PT_B, 22);
      end

      curKey = KEY_B;
      for (int i = 0; i < 1000; i++) begin
         bit newKey;
         newKey = (i == 0) || ($urandom_range(0, 1) == 1);
         if (newKey) curKey = {$urandom, $urandom, $urandom, $urandom};
         image = {$urandom, $urandom, $urandom, $urandom};
         ct    = encryptModel(image, curKey);
         applyStimulus(ct, curKey);
         waitForOutput(lat);
         checkOutput("rt-lat", 128'(lat), newKey ? 128'd22 : 128'd12);
         drainRandom(got);
         checkOutput("rt-pt", got, image);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
